// File: rtl/collatz_run_ctrl_pkg.sv
// Shared types for the collatz run/step/halt sequencer.
package collatz_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam int unsigned DEF_BITS     = 160;
    localparam int unsigned DEF_CNT_BITS = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic pulse
);

    // sr[1:0] is the synchroniser, sr[2] holds the previous synchronised level
    logic [2:0] sr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sr <= '0;
        else         sr <= {sr[1:0], din};
    end

    assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/collatz_run_ctrl.sv
// Run/step/halt sequencer for the collatz engine: owns clken, counts steps per
// start value, tracks the record holder and publishes a per-frame snapshot.
module collatz_run_ctrl
    import collatz_run_ctrl_pkg::*;
#(
    parameter int unsigned         BITS       = DEF_BITS,
    parameter int unsigned         CNT_BITS   = DEF_CNT_BITS,
    parameter logic [CNT_BITS-1:0] STEP_LIMIT = '1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    input  logic                step,
    input  logic                clear,
    input  logic                vsync,
    input  logic [BITS-1:0]     start,
    input  logic [BITS-1:0]     actual,
    output logic                clken,
    output logic                halted,
    output logic [BITS-1:0]     snap_start,
    output logic [BITS-1:0]     snap_actual,
    output logic [CNT_BITS-1:0] snap_steps,
    output logic [CNT_BITS-1:0] snap_rec_steps,
    output logic [BITS-1:0]     snap_rec_start,
    output logic                snap_valid
);

    state_t              state;
    logic [CNT_BITS-1:0] steps, rec_steps, steps_cnt;
    logic [BITS-1:0]     start_q, rec_start;
    logic                frame_edge, freeze, done, halt_go;

    sync_edge_detect u_vsync (
        .clk    (clk),
        .resetn (resetn),
        .din    (vsync),
        .pulse  (frame_edge)
    );

    assign done = (start != start_q);

    // A completion cycle may also carry an engine step; that step belongs to
    // the new start value, so it is counted rather than lost.
    always_comb begin
        steps_cnt = done ? '0 : steps;
        steps_cnt = steps_cnt + CNT_BITS'(clken);
    end

    // Halting on the next count drops clken at the same edge, so the count
    // can never run past the limit.
    assign halt_go = (state != ST_HALT) && (steps_cnt == STEP_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            clken     <= 1'b0;
            halted    <= 1'b0;
            steps     <= '0;
            rec_steps <= '0;
            rec_start <= '0;
            start_q   <= '0;
        end else begin
            start_q <= start;
            steps   <= steps_cnt;
            if (done && (steps > rec_steps)) begin
                rec_steps <= steps;
                rec_start <= start_q;
            end
            if (halt_go) begin
                state  <= ST_HALT;
                clken  <= 1'b0;
                halted <= 1'b1;
            end else begin
                if (clear) begin
                    steps     <= '0;
                    rec_steps <= '0;
                    rec_start <= '0;
                end
                case (state)
                    ST_IDLE: begin
                        if (run) begin
                            state <= ST_RUN;
                            clken <= !frame_edge;
                        end else if (step) begin
                            state <= ST_SINGLE;
                            clken <= !frame_edge;
                        end else begin
                            clken <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!run) begin
                            state <= ST_IDLE;
                            clken <= 1'b0;
                        end else begin
                            clken <= !frame_edge;
                        end
                    end
                    ST_SINGLE: begin
                        // clken low here means the step was pushed back by a freeze
                        if (clken) begin
                            state <= ST_IDLE;
                            clken <= 1'b0;
                        end else begin
                            clken <= !frame_edge;
                        end
                    end
                    ST_HALT: begin
                        clken <= 1'b0;
                        if (clear) begin
                            state  <= ST_IDLE;
                            halted <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        clken <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The engine is frozen during the capture cycle, so all fields are coherent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            freeze         <= 1'b0;
            snap_valid     <= 1'b0;
            snap_start     <= '0;
            snap_actual    <= '0;
            snap_steps     <= '0;
            snap_rec_steps <= '0;
            snap_rec_start <= '0;
        end else begin
            freeze     <= frame_edge;
            snap_valid <= freeze;
            if (freeze) begin
                snap_start     <= start;
                snap_actual    <= actual;
                snap_steps     <= steps;
                snap_rec_steps <= rec_steps;
                snap_rec_start <= rec_start;
            end
        end
    end

endmodule
